// File: rtl/paicore_axis_tlast_gen_if.sv
// AXI-Stream beat bundle (valid/ready/data/last) shared by the framing stage and its bench.
// The master drives valid/data/last and the slave drives ready.
interface paicore_axis_tlast_gen_if #(
  parameter int DATA_WD = 64
);
  logic               tvalid;
  logic               tready;
  logic [DATA_WD-1:0] tdata;
  logic               tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/paicore_axis_tlast_gen.sv
// Regenerates tlast on an untrusted DMA stream so each frame is exactly send_len beats; 1-cycle latency.
// Backpressure: registered 2-entry skid, s_axis.tready drops the cycle after a stalled beat lands in the skid.
module paicore_axis_tlast_gen #(
  parameter int DATA_WD = 64
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     start,
  input  logic [31:0]              send_len,
  paicore_axis_tlast_gen_if.slave  s_axis,
  paicore_axis_tlast_gen_if.master m_axis,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              frame_cnt,
  output logic                     len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        rem_q, rem_d;
  logic               rdy_q, rdy_d;
  logic               out_vld_q, out_vld_d;
  logic [DATA_WD-1:0] out_dat_q, out_dat_d;
  logic               out_last_q, out_last_d;
  logic               skid_vld_q, skid_vld_d;
  logic [DATA_WD-1:0] skid_dat_q, skid_dat_d;
  logic               skid_last_q, skid_last_d;
  logic               done_q, done_d;
  logic [31:0]        beat_cnt_q, beat_cnt_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;
  logic               len_err_q, len_err_d;

  logic               in_hs;
  logic               out_hs;
  logic               in_last;
  logic               out_free;

  assign in_hs    = s_axis.tvalid && rdy_q;
  assign out_hs   = out_vld_q && m_axis.tready;
  assign in_last  = (rem_q == 32'd1);
  assign out_free = !out_vld_q || m_axis.tready;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    len_err_d   = len_err_q;

    if (out_hs) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          beat_cnt_d = '0;
          len_err_d  = 1'b0;
          if (send_len != 32'd0) begin
            rem_d   = send_len;
            state_d = RUN;
          end else begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      RUN: begin
        if (in_hs) begin
          rem_d = rem_q - 32'd1;
          // Upstream tlast is only audited; framing always follows the programmed length.
          if (s_axis.tlast != in_last) begin
            len_err_d = 1'b1;
          end
          if (in_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs && out_last_q) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 32'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;

    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_last_d = skid_last_q;
        skid_vld_d = in_hs;
        if (in_hs) begin
          skid_dat_d  = s_axis.tdata;
          skid_last_d = in_last;
        end
      end else begin
        out_vld_d = in_hs;
        if (in_hs) begin
          out_dat_d  = s_axis.tdata;
          out_last_d = in_last;
        end
      end
    end else if (in_hs) begin
      // Output stalled: the beat already in flight parks in the skid entry.
      skid_vld_d  = 1'b1;
      skid_dat_d  = s_axis.tdata;
      skid_last_d = in_last;
    end

    rdy_d = (state_d == RUN) && !skid_vld_d;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      rdy_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
      done_q      <= 1'b0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rdy_q       <= rdy_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
      done_q      <= done_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  assign s_axis.tready = rdy_q;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_dat_q;
  assign m_axis.tlast  = out_last_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;
  assign beat_cnt      = beat_cnt_q;
  assign frame_cnt     = frame_cnt_q;
  assign len_err       = len_err_q;

endmodule
